imem_fetch_sequencer: RTL
=========================

Name: imem_fetch_sequencer

Overview:
- Owns the single-port instruction memory and sequences its use.
- After reset, a program loader has the memory for boot-time writes. Once the loader signals done, the block issues sequential fetches for the fetch stage.
- Handles memory-stage PC redirects and decode stalls, including a skid register for a read that returns while stalled.
- Sits between the loader, the instruction memory, and the fetch/decode pipeline register.

Parameters:
- ADDR_WIDTH, 12, word-address width of the instruction memory (4096 x 16-bit).
- PC_RESET, 16'h0000, byte PC of the first fetch after boot.
- PC_STEP, 2, byte increment per sequential fetch.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- ld_valid  input  1  loader write request
- ld_ready  output  1  block accepts loader writes (boot state only)
- ld_addr  input  16  loader byte address
- ld_data  input  16  loader write data
- ld_done  input  1  loader finished (single-cycle pulse)
- stall  input  1  decode cannot accept; hold outputs
- redirect  input  1  memory-stage PC select (taken branch/jump)
- redirect_pc  input  16  redirect target byte PC
- mem_en  output  1  memory enable
- mem_rd_en  output  1  memory read enable
- mem_wr_en  output  1  memory write enable
- mem_addr  output  ADDR_WIDTH  memory word address (byte PC bits [ADDR_WIDTH:1])
- mem_din  output  16  memory write data
- mem_dout  input  16  memory read data; valid the cycle after a read is issued
- instr  output  16  fetched instruction (registered)
- pc_out  output  16  byte PC of instr
- instr_valid  output  1  instr/pc_out hold a valid instruction
- load_count  output  13  words written during boot, saturating at 8191
- misalign_err  output  1  sticky: odd redirect_pc seen

Behaviour:
- Reset (async, high) forces:
  - state BOOT; req_pc=PC_RESET.
  - inflight=0, skid_valid=0.
  - instr=0, pc_out=0, instr_valid=0.
  - load_count=0, misalign_err=0.
  - All mem_* outputs are 0. Memory contents are not cleared.
- States: BOOT -> FETCH only. There is no return to BOOT except by reset.
- BOOT:
  - ld_ready=1.
  - When ld_valid=1, the write happens that cycle: mem_en=1, mem_wr_en=1, mem_addr=ld_addr[ADDR_WIDTH:1], mem_din=ld_data. load_count increments.
  - When ld_done=1, the next state is FETCH. If ld_valid and ld_done are high in the same cycle, the write still completes.
  - stall and redirect are ignored in BOOT. instr_valid stays 0.
- FETCH:
  - ld_ready=0. ld_valid and ld_done are ignored, with no writes.
  - Issue condition: issue = !stall.
  - On issue: mem_en=1, mem_rd_en=1, mem_addr from fpc, where fpc = redirect ? {redirect_pc[15:1],1'b0} : req_pc. At the clock edge: req_pc<=fpc+PC_STEP (mod 2^16), inflight<=1, inflight_pc<=fpc.
  - When not issuing, mem_en=0 and inflight<=0.
- Latency: a read issued in cycle N gives mem_dout in N+1. That value is registered into instr at the end of N+1 and is visible in N+2 with instr_valid=1 and pc_out=its PC.
- Not stalled, no redirect, at the edge:
  - If skid_valid: load outputs from skid, then clear skid_valid.
  - Else if inflight: load outputs from mem_dout/inflight_pc.
  - Else: instr_valid<=0.
- Stall, no redirect:
  - instr, pc_out and instr_valid hold.
  - If inflight: skid<=mem_dout, skid_pc<=inflight_pc, skid_valid<=1.
  - Stall release resumes at req_pc. No instruction is lost or duplicated.
- Redirect without stall:
  - The in-flight read is squashed: instr_valid<=0 and skid_valid<=0.
  - The read is issued at the target in the same cycle, giving exactly one bubble.
- Redirect with stall (redirect has priority over stall's hold):
  - req_pc<=target, instr_valid<=0, skid_valid<=0, inflight<=0.
  - No read is issued.
- Odd redirect_pc: bit 0 is forced to 0 and misalign_err<=1 (sticky until reset).
- Wrap-around:
  - req_pc wraps 16'hFFFE -> 16'h0000.
  - mem_addr aliases every 2^(ADDR_WIDTH+1) bytes.
  - load_count saturates.
- Reset mid-operation: instr_valid drops immediately. Fetch restarts only after a new BOOT/ld_done.

Test Plan:
- Boot load: write 16'h1111, 16'h2222, 16'h3333 to byte addresses 0, 2, 4, then pulse ld_done -> mem_wr_en high on 3 cycles; load_count=3; ld_ready falls the cycle after ld_done.
- Sequential fetch: after boot with no stall -> instr_valid first high 2 cycles after entering FETCH; pc_out/instr = 0/1111, 2/2222, 4/3333 on consecutive cycles.
- Stall: assert stall for 3 cycles while pc_out=2 -> outputs hold 2/2222. On release: 4/3333, then 6/mem[3]. No gap, no repeat.
- Redirect: redirect=1, redirect_pc=16'h0000 while pc_out=4 -> one cycle instr_valid=0, then pc_out=0, 2, 4.
- Redirect with odd target 16'h0003 during stall -> misalign_err=1; instr_valid=0 while stalled; first fetch at pc 2 after release.
- Async reset asserted mid-fetch (between clock edges) -> instr_valid=0 and ld_ready=1 immediately after release. A fresh ld_done restarts fetch at PC_RESET with memory contents preserved.

Source files
------------

// File: rtl/imem_fetch_sequencer.sv
// imem_fetch_sequencer
//
// Purpose:
//   Owns the single-port instruction memory and sequences its use.
//   - After reset the block sits in BOOT and lends the memory port to a
//     program loader for write-only access.
//   - A one-cycle ld_done pulse moves it permanently into FETCH.
//   - In FETCH it issues sequential word reads for the fetch stage and
//     follows memory-stage redirects.
//   - It honours decode stalls and parks a read that returns while
//     stalled in a skid register, so no instruction is lost or repeated.
//
// Ports:
//   clk, reset               - clock, asynchronous active-high reset
//   ld_valid/ld_ready        - loader write handshake (BOOT only)
//   ld_addr, ld_data         - loader byte address and write data
//   ld_done                  - loader finished (single-cycle pulse)
//   stall                    - decode cannot accept; hold instr outputs
//   redirect, redirect_pc    - taken branch/jump from the memory stage
//   mem_en/rd_en/wr_en       - memory strobes
//   mem_addr, mem_din        - memory word address and write data
//   mem_dout                 - memory read data, valid one cycle after a read
//   instr, pc_out            - registered instruction and its byte PC
//   instr_valid              - instr/pc_out hold a valid instruction
//   load_count               - boot words written, saturating at 8191
//   misalign_err             - sticky flag: an odd redirect target was seen
module imem_fetch_sequencer #(
  parameter int          ADDR_WIDTH = 12,
  parameter logic [15:0] PC_RESET   = 16'h0000,
  parameter logic [15:0] PC_STEP    = 16'd2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [15:0]           ld_addr,
  input  logic [15:0]           ld_data,
  input  logic                  ld_done,
  input  logic                  stall,
  input  logic                  redirect,
  input  logic [15:0]           redirect_pc,
  output logic                  mem_en,
  output logic                  mem_rd_en,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [15:0]           mem_din,
  input  logic [15:0]           mem_dout,
  output logic [15:0]           instr,
  output logic [15:0]           pc_out,
  output logic                  instr_valid,
  output logic [12:0]           load_count,
  output logic                  misalign_err
);

  typedef enum logic {
    ST_BOOT,
    ST_FETCH
  } state_t;

  localparam logic [12:0] LOAD_COUNT_MAX = 13'h1FFF;

  state_t      state_q, state_d;
  logic [15:0] req_pc_q, req_pc_d;
  logic        inflight_q, inflight_d;
  logic [15:0] inflight_pc_q, inflight_pc_d;
  logic        skid_valid_q, skid_valid_d;
  logic [15:0] skid_q, skid_d;
  logic [15:0] skid_pc_q, skid_pc_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] pc_out_q, pc_out_d;
  logic        instr_valid_q, instr_valid_d;
  logic [12:0] load_count_q, load_count_d;
  logic        misalign_q, misalign_d;

  logic [15:0]           fpc;
  logic                  issue;
  logic                  mem_en_c;
  logic                  mem_rd_en_c;
  logic                  mem_wr_en_c;
  logic [ADDR_WIDTH-1:0] mem_addr_c;
  logic [15:0]           mem_din_c;

  // Bits of the byte addresses that never reach the word-addressed memory
  // (bit 0 and anything above the memory size) are deliberately dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{ld_addr, fpc[0]};

  // Next-state and memory-port logic. The memory strobes are combinational
  // so a loader write or a fetch read happens in the cycle it is requested.
  always_comb begin
    state_d       = state_q;
    req_pc_d      = req_pc_q;
    inflight_d    = inflight_q;
    inflight_pc_d = inflight_pc_q;
    skid_valid_d  = skid_valid_q;
    skid_d        = skid_q;
    skid_pc_d     = skid_pc_q;
    instr_d       = instr_q;
    pc_out_d      = pc_out_q;
    instr_valid_d = instr_valid_q;
    load_count_d  = load_count_q;
    misalign_d    = misalign_q;

    mem_en_c    = 1'b0;
    mem_rd_en_c = 1'b0;
    mem_wr_en_c = 1'b0;
    mem_addr_c  = '0;
    mem_din_c   = '0;

    // A redirect target always has bit 0 cleared; the odd case is flagged.
    fpc   = redirect ? {redirect_pc[15:1], 1'b0} : req_pc_q;
    issue = 1'b0;

    case (state_q)
      ST_BOOT: begin
        if (ld_valid) begin
          mem_en_c    = 1'b1;
          mem_wr_en_c = 1'b1;
          mem_addr_c  = ld_addr[ADDR_WIDTH:1];
          mem_din_c   = ld_data;
          if (load_count_q != LOAD_COUNT_MAX) begin
            load_count_d = load_count_q + 13'd1;
          end
        end
        if (ld_done) begin
          state_d = ST_FETCH;
        end
      end

      ST_FETCH: begin
        issue = !stall;

        if (redirect && redirect_pc[0]) begin
          misalign_d = 1'b1;
        end

        if (issue) begin
          mem_en_c      = 1'b1;
          mem_rd_en_c   = 1'b1;
          mem_addr_c    = fpc[ADDR_WIDTH:1];
          req_pc_d      = fpc + PC_STEP;
          inflight_d    = 1'b1;
          inflight_pc_d = fpc;
        end else begin
          inflight_d = 1'b0;
        end

        if (redirect) begin
          // Squash whatever was in flight or parked; the target read (if
          // issued this cycle) is the next thing to appear.
          instr_valid_d = 1'b0;
          skid_valid_d  = 1'b0;
          if (stall) begin
            req_pc_d = fpc;
          end
        end else if (!stall) begin
          // A parked read is older than the one returning now, and while
          // anything was parked no read was outstanding, so skid goes first.
          if (skid_valid_q) begin
            instr_d       = skid_q;
            pc_out_d      = skid_pc_q;
            instr_valid_d = 1'b1;
            skid_valid_d  = 1'b0;
          end else if (inflight_q) begin
            instr_d       = mem_dout;
            pc_out_d      = inflight_pc_q;
            instr_valid_d = 1'b1;
          end else begin
            instr_valid_d = 1'b0;
          end
        end else begin
          // Outputs hold; a read returning now would otherwise be lost.
          if (inflight_q) begin
            skid_d       = mem_dout;
            skid_pc_d    = inflight_pc_q;
            skid_valid_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  // All state lives in this one register block.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_BOOT;
      req_pc_q      <= PC_RESET;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      skid_valid_q  <= 1'b0;
      skid_q        <= '0;
      skid_pc_q     <= '0;
      instr_q       <= '0;
      pc_out_q      <= '0;
      instr_valid_q <= 1'b0;
      load_count_q  <= '0;
      misalign_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      req_pc_q      <= req_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      skid_valid_q  <= skid_valid_d;
      skid_q        <= skid_d;
      skid_pc_q     <= skid_pc_d;
      instr_q       <= instr_d;
      pc_out_q      <= pc_out_d;
      instr_valid_q <= instr_valid_d;
      load_count_q  <= load_count_d;
      misalign_q    <= misalign_d;
    end
  end

  // The memory port is forced idle while reset is held, even if the
  // loader happens to be requesting a write at that moment.
  assign mem_en    = mem_en_c & ~reset;
  assign mem_rd_en = mem_rd_en_c & ~reset;
  assign mem_wr_en = mem_wr_en_c & ~reset;
  assign mem_addr  = reset ? '0 : mem_addr_c;
  assign mem_din   = reset ? '0 : mem_din_c;

  assign ld_ready     = (state_q == ST_BOOT);
  assign instr        = instr_q;
  assign pc_out       = pc_out_q;
  assign instr_valid  = instr_valid_q;
  assign load_count   = load_count_q;
  assign misalign_err = misalign_q;

endmodule
